// File: rtl/mic_pkg.sv
// -----------------------------------------------------------------------------
// mic_pkg
// Shared definitions for the microphone frame buffer.
//   rd_state_t        : read-side FSM states (IDLE, FETCH, SEND)
//   FRAME_LEN_DEFAULT : default samples per frame
//   IDX_W             : index width for the default frame length
//   CNT_W             : width of the saturating dropped-sample counter
//   idx_width()       : index width for any power-of-two frame length
// -----------------------------------------------------------------------------
package mic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2
    } rd_state_t;

    localparam int FRAME_LEN_DEFAULT = 256;
    localparam int IDX_W             = $clog2(FRAME_LEN_DEFAULT);
    localparam int CNT_W             = 16;

    function automatic int idx_width(input int frame_len);
        return $clog2(frame_len);
    endfunction

endpackage

// File: rtl/mic_frame_buffer_if.sv
// -----------------------------------------------------------------------------
// mic_frame_buffer_if
// Bundles the capture-side sample stream and the consumer-side frame stream.
//   in_valid / in_data              : one-cycle sample pulse, no back-pressure
//   out_valid / out_ready           : frame word handshake
//   out_data / out_last             : frame word and end-of-frame marker
//   overflow                        : one-cycle pulse per dropped sample
// Handshake: a word moves when out_valid and out_ready are both high on a
// rising bclk edge; while out_valid is high and out_ready low, out_data and
// out_last hold their value. in_valid has no ready and is never stalled.
// Modports:
//   master : the frame buffer itself (owns the output stream)
//   slave  : the surrounding capture stage and frame consumer
// -----------------------------------------------------------------------------
interface mic_frame_buffer_if #(
    parameter int N = 16
);
    logic         in_valid;
    logic [N-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    logic         out_last;
    logic         overflow;

    modport master (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output out_valid,
        output out_data,
        output out_last,
        output overflow
    );

    modport slave (
        output in_valid,
        output in_data,
        output out_ready,
        input  out_valid,
        input  out_data,
        input  out_last,
        input  overflow
    );
endinterface

// File: rtl/mic_frame_ram.sv
// -----------------------------------------------------------------------------
// mic_frame_ram
// Simple dual-port RAM holding both ping-pong banks, address = {bank, idx}.
//   bclk  : clock
//   we    : write enable, waddr / wdata written on the rising edge
//   re    : read enable, mem[raddr] appears on rdata one cycle later
//   rdata : registered read data (holds when re is low)
// -----------------------------------------------------------------------------
module mic_frame_ram #(
    parameter int N  = 16,
    parameter int AW = 9
) (
    input  logic          bclk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [N-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [N-1:0]  rdata
);

    logic [N-1:0] mem [2**AW];

    always_ff @(posedge bclk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/mic_frame_buffer.sv
// -----------------------------------------------------------------------------
// mic_frame_buffer
// Packs the live microphone sample stream into FRAME_LEN-sample frames in a
// two-bank ping-pong RAM and replays each completed frame as a valid/ready
// stream, oldest sample first, with out_last on the final word. When both
// banks hold unread frames, incoming samples are dropped and reported; the
// capture side is never stalled.
// Ports:
//   bclk          : single clock (shared with the capture stage)
//   reset         : synchronous, active-high
//   bus           : mic_frame_buffer_if.master (sample in, frame out, overflow)
//   dbg_rd_state  : current read FSM state
//   dropped_count : saturating count of dropped samples, only when the
//                   MIC_FRAME_DROP_CNT_EN macro is defined
// -----------------------------------------------------------------------------
module mic_frame_buffer
    import mic_pkg::*;
#(
    parameter int N         = 16,
    parameter int FRAME_LEN = FRAME_LEN_DEFAULT
) (
    input  logic                  bclk,
    input  logic                  reset,
    mic_frame_buffer_if.master    bus,
    output rd_state_t             dbg_rd_state
`ifdef MIC_FRAME_DROP_CNT_EN
    ,
    output logic [CNT_W-1:0]      dropped_count
`endif
);

    localparam int             IW       = idx_width(FRAME_LEN);
    localparam logic [IW-1:0]  LAST_IDX = IW'(FRAME_LEN - 1);

    // Write side
    logic          wr_bank;
    logic [IW-1:0] wr_idx;
    logic [1:0]    bank_full;
    logic [1:0]    bank_full_nxt;
    logic          hold;
    logic          other_free;
    logic          can_write;
    logic          eff_bank;
    logic          wr_en;
    logic          frame_done;

    // Read side
    rd_state_t     state;
    rd_state_t     state_nxt;
    logic          rd_bank;
    logic          rd_bank_nxt;
    logic [IW-1:0] rd_idx;
    logic [IW-1:0] rd_idx_nxt;
    logic          release_bank;
    logic          load_out;
    logic          ram_re;
    logic [IW:0]   ram_raddr;
    logic [N-1:0]  ram_rdata;

    logic [N-1:0]  out_data_q;
    logic          out_last_q;
    logic          overflow_q;

    // The writer only ever sits on a full bank while waiting for the other
    // bank (HOLD). The bank being released by the reader this very cycle
    // counts as free, so a sample arriving on the release cycle is kept.
    always_comb begin
        hold       = bank_full[wr_bank];
        other_free = !bank_full[!wr_bank] || (release_bank && (rd_bank != wr_bank));
        can_write  = !hold || other_free;
        eff_bank   = hold ? !wr_bank : wr_bank;
        wr_en      = bus.in_valid && can_write;
        frame_done = wr_en && (wr_idx == LAST_IDX);
    end

    always_comb begin
        bank_full_nxt = bank_full;
        if (release_bank) begin
            bank_full_nxt[rd_bank] = 1'b0;
        end
        if (frame_done) begin
            bank_full_nxt[eff_bank] = 1'b1;
        end
    end

    // Read FSM: every word costs a RAM read (IDLE/SEND) plus an output load
    // (FETCH), giving one word per two cycles at best.
    always_comb begin
        state_nxt    = state;
        rd_bank_nxt  = rd_bank;
        rd_idx_nxt   = rd_idx;
        release_bank = 1'b0;
        load_out     = 1'b0;
        ram_re       = 1'b0;
        ram_raddr    = {rd_bank, rd_idx};
        case (state)
            IDLE: begin
                if (bank_full[rd_bank]) begin
                    ram_re     = 1'b1;
                    ram_raddr  = {rd_bank, {IW{1'b0}}};
                    rd_idx_nxt = '0;
                    state_nxt  = FETCH;
                end
            end
            FETCH: begin
                load_out  = 1'b1;
                state_nxt = SEND;
            end
            SEND: begin
                if (bus.out_ready) begin
                    if (out_last_q) begin
                        release_bank = 1'b1;
                        rd_bank_nxt  = !rd_bank;
                        state_nxt    = IDLE;
                    end else begin
                        ram_re     = 1'b1;
                        ram_raddr  = {rd_bank, rd_idx + IW'(1)};
                        rd_idx_nxt = rd_idx + IW'(1);
                        state_nxt  = FETCH;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge bclk) begin
        if (reset) begin
            state      <= IDLE;
            rd_bank    <= 1'b0;
            rd_idx     <= '0;
            wr_bank    <= 1'b0;
            wr_idx     <= '0;
            bank_full  <= '0;
            out_data_q <= '0;
            out_last_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            rd_bank    <= rd_bank_nxt;
            rd_idx     <= rd_idx_nxt;
            bank_full  <= bank_full_nxt;
            overflow_q <= bus.in_valid && !can_write;

            if (wr_en) begin
                if (frame_done) begin
                    // Completing a frame: move on if the other bank can take
                    // the next sample, otherwise park here in HOLD.
                    wr_idx  <= '0;
                    wr_bank <= other_free ? !wr_bank : wr_bank;
                end else begin
                    wr_idx  <= wr_idx + IW'(1);
                    wr_bank <= eff_bank;
                end
            end else if (hold && other_free) begin
                wr_bank <= !wr_bank;
            end

            if (load_out) begin
                out_data_q <= ram_rdata;
                out_last_q <= (rd_idx == LAST_IDX);
            end
        end
    end

`ifdef MIC_FRAME_DROP_CNT_EN
    always_ff @(posedge bclk) begin
        if (reset) begin
            dropped_count <= '0;
        end else if (bus.in_valid && !can_write && (dropped_count != {CNT_W{1'b1}})) begin
            dropped_count <= dropped_count + CNT_W'(1);
        end
    end
`endif

    mic_frame_ram #(
        .N  (N),
        .AW (IW + 1)
    ) u_ram (
        .bclk  (bclk),
        .we    (wr_en),
        .waddr ({eff_bank, wr_idx}),
        .wdata (bus.in_data),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    assign bus.out_valid = (state == SEND);
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.overflow  = overflow_q;
    assign dbg_rd_state  = state;

endmodule
